// File: rtl/alpaca_dtypes_pkg.sv
// Shared data types for the ALPACA capture path: complex sample, capture FSM
// state and the status flags derived from it.
package alpaca_dtypes_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic busy;
        logic adc_en;
    } cap_status_t;

    function automatic cap_status_t status_of(cap_state_e s);
        cap_status_t st;
        st.busy   = (s == ST_ARMED) || (s == ST_CAPTURE);
        st.adc_en = st.busy;
        return st;
    endfunction

    // A zero length means "whole buffer"; anything larger than the buffer is cut to it.
    function automatic int unsigned clamp_len(int unsigned len, int unsigned depth);
        if (len == 0 || len > depth)
            return depth;
        return len;
    endfunction

endpackage

// File: rtl/alpaca_data_pkt_axis.sv
// Beat stream of samp_per_clk complex samples; no backpressure is expected
// from the slave side.
interface alpaca_data_pkt_axis
    import alpaca_dtypes_pkg::*;
#(
    parameter int samp_per_clk = 2
);
    cx_t [samp_per_clk-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport SLV (input tdata, input tvalid, output tready);
    modport MST (output tdata, output tvalid, input tready);
endinterface

// File: rtl/capture_skip_counter.sv
// Decimation gate: after each stored beat it is reloaded with the skip count
// and then counts valid beats down to zero; take is high when the next valid beat is kept.
module capture_skip_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic       take
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign take = (cnt == 8'd0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Arms on request, starts storing on a trigger beat, decimates the ADC stream
// into the capture buffer and reports completion with a one-cycle done pulse.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ADC off, waiting for arm; count holds the last result
// ST_ARMED   | ADC on, waiting for trig on a valid beat
// ST_CAPTURE | storing one beat, then dropping cfg_skip valid beats
// ST_DONE    | last write in flight; done pulses as we return to idle
module adc_capture_ctrl
    import alpaca_dtypes_pkg::*;
#(
    parameter int SAMP_PER_CLK = 2,
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         trig,
    input  logic                         abort,
    input  logic [ADDR_W:0]              cfg_len,
    input  logic [7:0]                   cfg_skip,
    alpaca_data_pkt_axis.SLV             s_axis,
    output logic                         adc_en,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output cx_t  [SAMP_PER_CLK-1:0]      wr_data,
    output logic                         busy,
    output logic                         done,
    output logic [ADDR_W:0]              count
);

    cap_state_e      state;
    cap_state_e      state_nxt;
    cap_status_t     status;
    logic [ADDR_W:0] len_q;
    logic [7:0]      skip_q;
    logic [ADDR_W:0] count_inc;
    logic            arm_hit;
    logic            trig_hit;
    logic            cap_beat;
    logic            take;
    logic            store;
    logic            last;

    assign s_axis.tready = 1'b1;

    assign arm_hit   = (state == ST_IDLE) && arm && !abort;
    assign trig_hit  = (state == ST_ARMED) && trig && s_axis.tvalid;
    assign cap_beat  = (state == ST_CAPTURE) && s_axis.tvalid;
    assign store     = !abort && (trig_hit || (cap_beat && take));
    assign count_inc = count + 1'b1;
    assign last      = store && (count_inc == len_q);

    capture_skip_counter u_skip (
        .clk      (clk),
        .rst      (rst),
        .clr      (arm_hit),
        .load     (store),
        .dec      (cap_beat && !take && !abort),
        .load_val (skip_q),
        .take     (take)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (arm) state_nxt = ST_ARMED;
                ST_ARMED:   if (trig_hit) state_nxt = last ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE: if (last) state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            skip_q  <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            wr_en <= store;
            // done trails the final write by one cycle and is suppressed by abort
            done  <= (state == ST_DONE) && !abort;
            if (arm_hit) begin
                len_q   <= (ADDR_W+1)'(clamp_len(32'(cfg_len), DEPTH));
                skip_q  <= cfg_skip;
                count   <= '0;
                wr_addr <= '0;
            end
            if (store) begin
                wr_addr <= count[ADDR_W-1:0];
                wr_data <= s_axis.tdata;
                count   <= count_inc;
            end
        end
    end

    assign status = status_of(state);
    assign busy   = status.busy;
    assign adc_en = status.adc_en;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: table of capture scenarios driven
// with random beats against a decimation model, plus abort and reset sequences.
module tb_adc_capture_ctrl;
    import alpaca_dtypes_pkg::*;

    localparam int SPC   = 2;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic             trig;
    logic             abort;
    logic [AW:0]      cfg_len;
    logic [7:0]       cfg_skip;
    logic             adc_en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    cx_t  [SPC-1:0]   wr_data;
    logic             busy;
    logic             done;
    logic [AW:0]      count;

    alpaca_data_pkt_axis #(.samp_per_clk(SPC)) axis ();

    adc_capture_ctrl #(.SAMP_PER_CLK(SPC), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig     (trig),
        .abort    (abort),
        .cfg_len  (cfg_len),
        .cfg_skip (cfg_skip),
        .s_axis   (axis),
        .adc_en   (adc_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sample_n = 0;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;
    wr_t expq[$];
    wr_t mon_e;

    typedef struct {
        int len;
        int skip;
        int vpct;
        bit tone;
        bit armtrig;
        int exp_len;
    } vec_t;
    vec_t vecs[8];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Tone source standing in for the ADC, normalised frequency 0.08
    function automatic logic [63:0] adc_model(int n);
        logic [63:0] d;
        cx_t         c;
        real         ph;
        d = '0;
        for (int k = 0; k < SPC; k++) begin
            ph   = 2.0 * 3.141592653589793 * 0.08 * real'(n * SPC + k);
            c.re = 16'($rtoi(2047.0 * $cos(ph)));
            c.im = 16'($rtoi(2047.0 * $sin(ph)));
            d[k*32 +: 32] = c;
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (expq.size() == 0) begin
                chk("wr_unexpected", {63'd0, wr_en}, 64'd0);
            end else begin
                mon_e = expq.pop_front();
                chk("wr_addr", {58'd0, wr_addr}, 64'(mon_e.addr));
                chk("wr_data", wr_data, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input bit a, input bit t, input bit ab,
                          input bit tone, output logic [63:0] d);
        d = tone ? adc_model(sample_n) : {$urandom, $urandom};
        sample_n++;
        axis.tdata  = d;
        axis.tvalid = v;
        arm         = a;
        trig        = t;
        abort       = ab;
    endtask

    task automatic check_idle_zero(string tag);
        chk({tag, "_adc_en"}, {63'd0, adc_en}, 64'd0);
        chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_count"}, {57'd0, count}, 64'd0);
        chk({tag, "_wr_addr"}, {58'd0, wr_addr}, 64'd0);
        chk({tag, "_wr_data"}, wr_data, 64'd0);
    endtask

    // Arms, triggers and then streams beats until the model has stored
    // stop_at beats (or the full clamped length when stop_at is 0).
    task automatic start_capture(input vec_t vc, input int stop_at, output int stored);
        logic [63:0] d;
        int          vidx;
        bit          v;
        int          target;
        target   = (stop_at > 0) ? stop_at : vc.exp_len;
        cfg_len  = (AW+1)'(vc.len);
        cfg_skip = 8'(vc.skip);
        set_in(1, 1, vc.armtrig, 0, vc.tone, d);
        tick();
        chk("arm_busy", {63'd0, busy}, 64'd1);
        chk("arm_adc_en", {63'd0, adc_en}, 64'd1);
        chk("arm_count_clr", {57'd0, count}, 64'd0);
        set_in(1, 0, 0, 0, vc.tone, d);
        tick();
        set_in(0, 0, 1, 0, vc.tone, d);
        tick();
        chk("armed_hold_busy", {63'd0, busy}, 64'd1);
        chk("armed_no_store", {57'd0, count}, 64'd0);
        set_in(1, 0, 1, 0, vc.tone, d);
        expq.push_back('{0, d});
        stored = 1;
        vidx   = 1;
        tick();
        while (stored < target) begin
            v = ($urandom_range(99) < vc.vpct);
            set_in(v, ($urandom_range(19) == 0), ($urandom_range(19) == 0), 0, vc.tone, d);
            if (v) begin
                if (vidx % (vc.skip + 1) == 0) begin
                    expq.push_back('{stored, d});
                    stored++;
                end
                vidx++;
            end
            tick();
            if (stored < vc.exp_len)
                chk("capture_busy", {63'd0, busy}, 64'd1);
        end
    endtask

    task automatic run_capture(input vec_t vc);
        logic [63:0] d;
        int          stored;
        start_capture(vc, 0, stored);
        chk("last_wr_en", {63'd0, wr_en}, 64'd1);
        chk("done_not_early", {63'd0, done}, 64'd0);
        chk("final_count", {57'd0, count}, 64'(vc.exp_len));
        set_in($urandom_range(1), 0, 0, 0, vc.tone, d);
        tick();
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
        set_in($urandom_range(1), 0, 0, 0, vc.tone, d);
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("idle_adc_en", {63'd0, adc_en}, 64'd0);
        chk("count_hold", {57'd0, count}, 64'(vc.exp_len));
        chk("writes_pending", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          stored;
        vec_t        vc;

        vecs[0] = '{64,  0, 100, 1'b1, 1'b0, 64};
        vecs[1] = '{8,   3, 100, 1'b0, 1'b0, 8};
        vecs[2] = '{16,  1, 50,  1'b0, 1'b0, 16};
        vecs[3] = '{0,   0, 100, 1'b0, 1'b1, 64};
        vecs[4] = '{100, 2, 70,  1'b0, 1'b0, 64};
        vecs[5] = '{1,   0, 100, 1'b0, 1'b0, 1};
        vecs[6] = '{2,   5, 60,  1'b0, 1'b0, 2};
        vecs[7] = '{40,  0, 80,  1'b0, 1'b1, 40};

        rst         = 1'b1;
        arm         = 1'b0;
        trig        = 1'b0;
        abort       = 1'b0;
        cfg_len     = '0;
        cfg_skip    = '0;
        axis.tdata  = '0;
        axis.tvalid = 1'b0;
        repeat (3) tick();
        check_idle_zero("reset");
        chk("tready", {63'd0, axis.tready}, 64'd1);
        rst = 1'b0;
        tick();

        // trig in IDLE must not start anything
        set_in(1, 0, 1, 0, 0, d);
        tick();
        chk("idle_trig_busy", {63'd0, busy}, 64'd0);
        chk("idle_trig_count", {57'd0, count}, 64'd0);

        for (int i = 0; i < 8; i++)
            run_capture(vecs[i]);

        // abort at count=10 of a 32-beat capture
        vc = '{32, 0, 100, 1'b0, 1'b0, 32};
        start_capture(vc, 10, stored);
        chk("pre_abort_count", {57'd0, count}, 64'd10);
        set_in(1, 0, 0, 1, 0, d);
        tick();
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_adc_en", {63'd0, adc_en}, 64'd0);
        chk("abort_count", {57'd0, count}, 64'd10);
        chk("abort_wr_en", {63'd0, wr_en}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, d);
            tick();
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        chk("abort_writes_pending", 64'(expq.size()), 64'd0);

        // reset mid-capture overrides abort/arm/trig
        vc = '{16, 0, 100, 1'b0, 1'b0, 16};
        start_capture(vc, 5, stored);
        set_in(1, 1, 1, 1, 0, d);
        rst = 1'b1;
        tick();
        check_idle_zero("midrst");
        rst = 1'b0;
        chk("midrst_writes_pending", 64'(expq.size()), 64'd0);
        run_capture(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
